// File: rtl/bcd_to_bin_seq_if.sv
// Handshake bundle for bcd_to_bin_seq: start/bcd request side, busy/done/binary/err result side.
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      binary;
    logic                  err;

    modport master (output start, bcd, input busy, done, binary, err);
    modport slave  (input start, bcd, output busy, done, binary, err);
endinterface

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one bit per clock.
// Optional invalid-digit detection enabled by defining BCD_TO_BIN_CHECK_EN.
module bcd_to_bin_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic            clk,
    input  logic            reset,
    bcd_to_bin_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIN_W-1:0]  binary_q, binary_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic              bad_digit_s;

    // Shift right one bit, then pull every digit field that reached 8 or more back down by 3.
    function automatic logic [SR_W-1:0] shift_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr >> 1;
        for (int d = 0; d < DIGITS; d++) begin
            t[BIN_W + 4*d +: 4] = t[BIN_W + 4*d + 3] ? (t[BIN_W + 4*d +: 4] - 4'd3)
                                                      : t[BIN_W + 4*d +: 4];
        end
        return t;
    endfunction

`ifdef BCD_TO_BIN_CHECK_EN
    function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            bad = bad | (v[4*d +: 4] > 4'd9);
        end
        return bad;
    endfunction

    assign bad_digit_s = has_bad_digit(bus.bcd);
`else
    assign bad_digit_s = 1'b0;
`endif

    // Next-state and output decode for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        binary_d = binary_q;
        err_d    = err_q;
        pend_d   = pend_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    sr_d    = {bus.bcd, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    pend_d  = bad_digit_s;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sr_d  = shift_step(sr_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // A flagged operand reports zero rather than a meaningless conversion.
                binary_d = pend_q ? {BIN_W{1'b0}} : sr_q[BIN_W-1:0];
                err_d    = pend_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            binary_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            binary_q <= binary_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.binary = binary_q;
    assign bus.err    = err_q;
endmodule
